// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if -- request/response bus of the sequential ALU.
//
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both 1; A, B and ALUop are sampled only on that edge. A
// response transfers on a rising edge where out_valid and out_ready are both
// 1; while out_valid is 1 and out_ready is 0, Result and the flags are held
// stable. Neither side may make its valid depend on the other side's ready.
//
// Signals:
//   in_valid, A, B, ALUop, out_ready : driven by the requester (master)
//   in_ready, out_valid, Result,
//   Overflow, CarryOut, Zero         : driven by the ALU (slave)
// ---------------------------------------------------------------------------
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALUop;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic             Overflow;
   logic             CarryOut;
   logic             Zero;

   modport master (
      output in_valid, A, B, ALUop, out_ready,
      input  in_ready, out_valid, Result, Overflow, CarryOut, Zero
   );

   modport slave (
      input  in_valid, A, B, ALUop, out_ready,
      output in_ready, out_valid, Result, Overflow, CarryOut, Zero
   );
endinterface

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- sequential ALU with a valid/ready request and response.
//
// Single-cycle ops finish one cycle after accept. MUL (shift-add) and
// DIVU/REMU (restoring division) iterate WIDTH times in BUSY, so they finish
// WIDTH+1 cycles after accept. Division by zero finishes in one cycle.
//
// Ports:
//   clk          : clock, rising edge
//   resetn       : asynchronous active-low reset
//   bus          : seq_alu_if slave modport (request, response, flags)
//   dbg_state_o  : FSM state, IDLE=0, BUSY=1, DONE=2
// ---------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       resetn,
   seq_alu_if.slave   bus,
   output logic [1:0] dbg_state_o
);
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SGE  = 4'b1111;
   localparam logic [3:0] OP_SLTU = 4'b1011;
   localparam logic [3:0] OP_SGEU = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_MUL  = 4'b1001;
   localparam logic [3:0] OP_DIVU = 4'b1010;
   localparam logic [3:0] OP_REMU = 4'b1110;

   localparam logic [SHW:0] LAST_ITER = (SHW+1)'(WIDTH-1);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

   state_e           state_q, state_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   // MUL: acc = partial product, x = shifted multiplicand, y = multiplier.
   // DIV: acc = partial remainder, x = dividend/quotient, y = divisor.
   logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             ov_q, ov_d, co_q, co_d, z_q, z_d;

   logic             in_ready, out_valid, accept, start_multi, last_iter;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ov, alu_co;
   logic [WIDTH:0]   sum, diff, trial, dstep;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] step_acc, step_x, step_y, busy_res;

   assign accept      = bus.in_valid && in_ready;
   assign start_multi = (bus.ALUop == OP_MUL) ||
                        (((bus.ALUop == OP_DIVU) || (bus.ALUop == OP_REMU)) && (bus.B != '0));
   assign last_iter   = (cnt_q == LAST_ITER);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = start_multi ? BUSY : DONE;
         BUSY:    if (last_iter) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready    = (state_q == IDLE);
      out_valid   = (state_q == DONE);
      dbg_state_o = state_q;
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.Result    = res_q;
   assign bus.Overflow  = ov_q;
   assign bus.CarryOut  = co_q;
   assign bus.Zero      = z_q;

   // ---------------- single-cycle result from the live request ----------------
   always_comb begin
      alu_res = '0;
      alu_ov  = 1'b0;
      alu_co  = 1'b0;
      sum     = {1'b0, bus.A} + {1'b0, bus.B};
      diff    = {1'b0, bus.A} - {1'b0, bus.B};
      sh      = bus.B[SHW-1:0];
      case (bus.ALUop)
         OP_AND:  alu_res = bus.A & bus.B;
         OP_OR:   alu_res = bus.A | bus.B;
         OP_XOR:  alu_res = bus.A ^ bus.B;
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_co  = sum[WIDTH];
            alu_ov  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_co  = diff[WIDTH];   // borrow out of the unsigned subtraction
            alu_ov  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) <  $signed(bus.B))};
         OP_SGE:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) >= $signed(bus.B))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.A <  bus.B)};
         OP_SGEU: alu_res = {{(WIDTH-1){1'b0}}, (bus.A >= bus.B)};
         OP_SLL:  alu_res = bus.A << sh;
         OP_SRL:  alu_res = bus.A >> sh;
         OP_SRA:  alu_res = $signed(bus.A) >>> sh;
         // Only reached with B == 0; nonzero divisors go through BUSY.
         OP_DIVU: alu_res = '1;
         OP_REMU: alu_res = bus.A;
         default: alu_res = '0;
      endcase
   end

   // ---------------- one iteration of the multi-cycle ops ----------------
   always_comb begin
      trial = {acc_q, x_q[WIDTH-1]};
      dstep = trial - {1'b0, y_q};
      if (op_q == OP_MUL) begin
         step_acc = y_q[0] ? (acc_q + x_q) : acc_q;
         step_x   = x_q << 1;
         step_y   = y_q >> 1;
      end else if (!dstep[WIDTH]) begin
         // Divisor fits: keep the difference and shift in a quotient 1.
         step_acc = dstep[WIDTH-1:0];
         step_x   = {x_q[WIDTH-2:0], 1'b1};
         step_y   = y_q;
      end else begin
         step_acc = trial[WIDTH-1:0];
         step_x   = {x_q[WIDTH-2:0], 1'b0};
         step_y   = y_q;
      end
      busy_res = (op_q == OP_DIVU) ? step_x : step_acc;
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      cnt_d = cnt_q;
      op_d  = op_q;
      acc_d = acc_q;
      x_d   = x_q;
      y_d   = y_q;
      res_d = res_q;
      ov_d  = ov_q;
      co_d  = co_q;
      z_d   = z_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d  = bus.ALUop;
               cnt_d = '0;
               if (start_multi) begin
                  acc_d = '0;
                  x_d   = bus.A;
                  y_d   = bus.B;
               end else begin
                  res_d = alu_res;
                  ov_d  = alu_ov;
                  co_d  = alu_co;
                  z_d   = (alu_res == '0);
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = step_acc;
            x_d   = step_x;
            y_d   = step_y;
            if (last_iter) begin
               res_d = busy_res;
               ov_d  = 1'b0;
               co_d  = 1'b0;
               z_d   = (busy_res == '0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
         op_q  <= '0;
         acc_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         res_q <= '0;
         ov_q  <= 1'b0;
         co_q  <= 1'b0;
         z_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         op_q  <= op_d;
         acc_q <= acc_d;
         x_q   <= x_d;
         y_q   <= y_d;
         res_q <= res_d;
         ov_q  <= ov_d;
         co_q  <= co_d;
         z_q   <= z_d;
      end
   end
endmodule
